// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU register-bus arbiter: FSM state codes, owner ids
// and the phase-counter width.
package cpu_bus_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

endpackage

// File: rtl/cpu_bus_arb_pick.sv
// Combinational grant selection between the two requesters.
// CPU_BUS_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module cpu_bus_arb_pick
  import cpu_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef CPU_BUS_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic gnt_valid,
  output logic gnt_owner
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_owner = OWN0;
`ifdef CPU_BUS_ARB_RR_EN
    if (req0 && req1) begin
      gnt_owner = (last_owner == OWN0) ? OWN1 : OWN0;
    end else if (req1) begin
      gnt_owner = OWN1;
    end
`else
    if (req1 && !req0) begin
      gnt_owner = OWN1;
    end
`endif
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Two-port arbiter and cycle sequencer for the 8-bit CPU register bus.
// Define CPU_BUS_ARB_RR_EN for round-robin tie-breaking (default: port 0 priority).
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic          clk_cpu,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          CS_,
  output logic          OE_,
  output logic          WR_,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] bus_dout,
  output logic          bus_doe,
  input  logic [DW-1:0] bus_din
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (SETUP_CYC < 1 || SETUP_CYC > CNT_MAX ||
      STROBE_CYC < 1 || STROBE_CYC > CNT_MAX ||
      HOLD_CYC < 1 || HOLD_CYC > CNT_MAX) begin : g_bad_timing
    $error("cpu_bus_arbiter: SETUP_CYC/STROBE_CYC/HOLD_CYC must each be in 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             op_wr;
  logic             gnt_valid;
  logic             gnt_owner;

`ifdef CPU_BUS_ARB_RR_EN
  logic last_owner;
`endif

  cpu_bus_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
`ifdef CPU_BUS_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= OWN0;
      op_wr    <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      CS_      <= 1'b1;
      OE_      <= 1'b1;
      WR_      <= 1'b1;
      Addr     <= '0;
      bus_dout <= '0;
      bus_doe  <= 1'b0;
`ifdef CPU_BUS_ARB_RR_EN
      last_owner <= OWN1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state <= SETUP;
            cnt   <= SETUP_LD;
            busy  <= 1'b1;
            CS_   <= 1'b0;
            owner <= gnt_owner;
`ifdef CPU_BUS_ARB_RR_EN
            last_owner <= gnt_owner;
`endif
            op_wr <= (gnt_owner == OWN1) ? wr1 : wr0;
            Addr  <= (gnt_owner == OWN1) ? addr1 : addr0;
            if ((gnt_owner == OWN1) ? wr1 : wr0) begin
              bus_dout <= (gnt_owner == OWN1) ? wdata1 : wdata0;
              bus_doe  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == CNT_ONE) begin
            state <= STROBE;
            cnt   <= STROBE_LD;
            if (op_wr) WR_ <= 1'b0;
            else       OE_ <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STROBE: begin
          if (cnt == CNT_ONE) begin
            state <= HOLD;
            cnt   <= HOLD_LD;
            OE_   <= 1'b1;
            WR_   <= 1'b1;
            if (!op_wr) rdata <= bus_din;
            // A single-cycle HOLD is also the ack cycle.
            if (HOLD_LD == CNT_ONE) begin
              ack0 <= (owner == OWN0);
              ack1 <= (owner == OWN1);
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin // HOLD
          if (cnt == CNT_ONE) begin
            state   <= IDLE;
            busy    <= 1'b0;
            CS_     <= 1'b1;
            bus_doe <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_TWO) begin
              ack0 <= (owner == OWN0);
              ack1 <= (owner == OWN1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: default timing instance plus a 3/1/2 timing
// instance. Tie expectations follow CPU_BUS_ARB_RR_EN.
module tb_cpu_bus_arbiter;

  logic       clk_cpu = 1'b0;
  logic       rst;
  logic       req0, req1, wr0, wr1;
  logic [7:0] addr0, addr1, wdata0, wdata1, bus_din;
  logic       ack0, ack1, busy, CS_, OE_, WR_, bus_doe;
  logic [7:0] rdata, Addr, bus_dout;

  logic       b_req0, b_req1;
  logic       b_ack0, b_ack1, b_busy, b_cs, b_oe, b_wr, b_doe;
  logic [7:0] b_rdata, b_addr, b_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk_cpu = ~clk_cpu;

  cpu_bus_arbiter dut (
    .clk_cpu (clk_cpu), .rst (rst),
    .req0 (req0), .req1 (req1), .wr0 (wr0), .wr1 (wr1),
    .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
    .ack0 (ack0), .ack1 (ack1), .rdata (rdata), .busy (busy),
    .CS_ (CS_), .OE_ (OE_), .WR_ (WR_), .Addr (Addr),
    .bus_dout (bus_dout), .bus_doe (bus_doe), .bus_din (bus_din)
  );

  cpu_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_b (
    .clk_cpu (clk_cpu), .rst (rst),
    .req0 (b_req0), .req1 (b_req1), .wr0 (wr0), .wr1 (wr1),
    .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
    .ack0 (b_ack0), .ack1 (b_ack1), .rdata (b_rdata), .busy (b_busy),
    .CS_ (b_cs), .OE_ (b_oe), .WR_ (b_wr), .Addr (b_addr),
    .bus_dout (b_dout), .bus_doe (b_doe), .bus_din (bus_din)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  int exp_own[4];
  int n_tx;

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; bus_din = 0;
    b_req0 = 0; b_req1 = 0;
    repeat (2) @(negedge clk_cpu);

    check("rst_cs", CS_, 1); check("rst_oe", OE_, 1); check("rst_wr", WR_, 1);
    check("rst_addr", Addr, 0); check("rst_dout", bus_dout, 0); check("rst_doe", bus_doe, 0);
    check("rst_ack0", ack0, 0); check("rst_ack1", ack1, 0);
    check("rst_rdata", rdata, 0); check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk_cpu);
    check("idle_cs", CS_, 1);

    // Write on port 0; address/data changed after the grant must be ignored.
    req0 = 1; wr0 = 1; addr0 = 8'h02; wdata0 = 8'hA5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_cpu);
      if (c == 1) begin addr0 = 8'hFF; wdata0 = 8'h00; end
      check($sformatf("wr_cs_c%0d", c), CS_, 0);
      check($sformatf("wr_wr_c%0d", c), WR_, (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("wr_oe_c%0d", c), OE_, 1);
      check($sformatf("wr_addr_c%0d", c), Addr, 8'h02);
      check($sformatf("wr_dout_c%0d", c), bus_dout, 8'hA5);
      check($sformatf("wr_doe_c%0d", c), bus_doe, 1);
      check($sformatf("wr_ack0_c%0d", c), ack0, (c == 4) ? 1 : 0);
      check($sformatf("wr_ack1_c%0d", c), ack1, 0);
      check($sformatf("wr_busy_c%0d", c), busy, 1);
    end
    check("wr_rdata_untouched", rdata, 0);
    req0 = 0;
    @(negedge clk_cpu);
    check("wr_idle_cs", CS_, 1); check("wr_idle_busy", busy, 0);
    check("wr_idle_doe", bus_doe, 0); check("wr_idle_ack0", ack0, 0);

    // Read on port 1; bus data is only valid during STROBE.
    req1 = 1; wr1 = 0; addr1 = 8'h03;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_cpu);
      if (c == 1) bus_din = 8'h5C;
      if (c == 4) bus_din = 8'h00;
      check($sformatf("rd_cs_c%0d", c), CS_, 0);
      check($sformatf("rd_oe_c%0d", c), OE_, (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("rd_wr_c%0d", c), WR_, 1);
      check($sformatf("rd_doe_c%0d", c), bus_doe, 0);
      check($sformatf("rd_addr_c%0d", c), Addr, 8'h03);
      check($sformatf("rd_ack1_c%0d", c), ack1, (c == 4) ? 1 : 0);
      check($sformatf("rd_ack0_c%0d", c), ack0, 0);
    end
    check("rd_rdata", rdata, 8'h5C);
    req1 = 0;
    @(negedge clk_cpu);
    check("rd_idle_cs", CS_, 1); check("rd_rdata_hold", rdata, 8'h5C);

    // Tie: both requesting writes.
`ifdef CPU_BUS_ARB_RR_EN
    exp_own = '{0, 1, 0, 1}; n_tx = 4;
`else
    exp_own = '{0, 0, 1, 0}; n_tx = 3;
`endif
    req0 = 1; req1 = 1; wr0 = 1; wr1 = 1;
    addr0 = 8'h10; addr1 = 8'h11; wdata0 = 8'h21; wdata1 = 8'h22;
    for (int t = 0; t < n_tx; t++) begin
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk_cpu);
        if (c == 1) begin
          check($sformatf("tie%0d_cs", t), CS_, 0);
          check($sformatf("tie%0d_addr", t), Addr, (exp_own[t] == 0) ? 8'h10 : 8'h11);
          check($sformatf("tie%0d_dout", t), bus_dout, (exp_own[t] == 0) ? 8'h21 : 8'h22);
        end
        if (c == 4) begin
          check($sformatf("tie%0d_ack0", t), ack0, (exp_own[t] == 0) ? 1 : 0);
          check($sformatf("tie%0d_ack1", t), ack1, (exp_own[t] == 1) ? 1 : 0);
`ifndef CPU_BUS_ARB_RR_EN
          if (t == 1) req0 = 0;
`endif
          if (t == n_tx - 1) begin req0 = 0; req1 = 0; end
        end
        if (c == 5) begin
          check($sformatf("tie%0d_idle_cs", t), CS_, 1);
          check($sformatf("tie%0d_idle_busy", t), busy, 0);
        end
      end
    end
    check("tie_rdata_hold", rdata, 8'h5C);

    // Timing 3/1/2 write on the second instance.
    wr0 = 1; addr0 = 8'h44; wdata0 = 8'h3C; b_req0 = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_cpu);
      check($sformatf("tm_cs_c%0d", c), b_cs, 0);
      check($sformatf("tm_wr_c%0d", c), b_wr, (c == 4) ? 0 : 1);
      check($sformatf("tm_ack0_c%0d", c), b_ack0, (c == 6) ? 1 : 0);
      if (c == 6) b_req0 = 0;
    end
    check("tm_addr", b_addr, 8'h44); check("tm_dout", b_dout, 8'h3C);
    @(negedge clk_cpu);
    check("tm_idle_cs", b_cs, 1); check("tm_idle_ack0", b_ack0, 0);
    check("main_idle_during_tm", CS_, 1);

    // Reset during the second STROBE cycle of a read.
    req1 = 1; wr1 = 0; addr1 = 8'h07; bus_din = 8'h99;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_cpu);
      if (c == 3) check("rr_oe_strobe2", OE_, 0);
    end
    rst = 1; req1 = 0;
    @(negedge clk_cpu);
    check("rr_cs", CS_, 1); check("rr_oe", OE_, 1); check("rr_wr", WR_, 1);
    check("rr_ack1", ack1, 0); check("rr_rdata", rdata, 0); check("rr_busy", busy, 0);
    rst = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_cpu);
      check($sformatf("rr_after_ack1_c%0d", c), ack1, 0);
      check($sformatf("rr_after_cs_c%0d", c), CS_, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
